frame_ctrl: RTL



---
 rtl/frame_ctrl.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/frame_ctrl.sv
// frame_ctrl: per-frame sequencer counting source and destination pixel beats, then posting end status to the CRF.
// Optional beat watchdog is built in when FRAME_CTRL_TIMEOUT_EN is defined.
module frame_ctrl #(
    parameter int SRC_IMG_WIDTH  = 1920,
    parameter int SRC_IMG_HEIGHT = 1080,
    parameter int DST_IMG_WIDTH  = 4096,
    parameter int DST_IMG_HEIGHT = 2160,
    parameter int CRF_DATA_WIDTH = 32,
    parameter int CRF_ADDR_WIDTH = 32,
    parameter logic [CRF_ADDR_WIDTH-1:0] UPENDR_ADDR = 'h4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CRF_DATA_WIDTH-1:0] crf_ac_UPSTR,
    input  logic                      crf_ac_wbusy,
    input  logic                      src_beat,
    input  logic                      dst_beat,
    output logic                      src_en,
    output logic                      dst_en,
    output logic                      dst_eol,
    output logic                      dst_eof,
    output logic                      ac_crf_wrt,
    output logic [CRF_ADDR_WIDTH-1:0] ac_crf_waddr,
    output logic [CRF_DATA_WIDTH-1:0] ac_crf_wdata,
    output logic                      busy,
    output logic                      done,
    output logic                      abort,
    output logic [2:0]                dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_DRAIN  = 3'd2,
        S_REPORT = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam int SCW = (SRC_IMG_WIDTH  > 1) ? $clog2(SRC_IMG_WIDTH)  : 1;
    localparam int SRW = (SRC_IMG_HEIGHT > 1) ? $clog2(SRC_IMG_HEIGHT) : 1;
    localparam int DCW = (DST_IMG_WIDTH  > 1) ? $clog2(DST_IMG_WIDTH)  : 1;
    localparam int DRW = (DST_IMG_HEIGHT > 1) ? $clog2(DST_IMG_HEIGHT) : 1;
    localparam logic [SCW-1:0] SC_MAX = SCW'(SRC_IMG_WIDTH - 1);
    localparam logic [SRW-1:0] SR_MAX = SRW'(SRC_IMG_HEIGHT - 1);
    localparam logic [DCW-1:0] DC_MAX = DCW'(DST_IMG_WIDTH - 1);
    localparam logic [DRW-1:0] DR_MAX = DRW'(DST_IMG_HEIGHT - 1);
    localparam logic [CRF_DATA_WIDTH-1:0] CODE_OK = CRF_DATA_WIDTH'(1);
    localparam logic [CRF_DATA_WIDTH-1:0] CODE_TO = CRF_DATA_WIDTH'(2);

    state_t                    r_state;
    logic [SCW-1:0]            r_src_col;
    logic [SRW-1:0]            r_src_row;
    logic [DCW-1:0]            r_dst_col;
    logic [DRW-1:0]            r_dst_row;
    logic                      r_start_q;
    logic                      r_src_en;
    logic                      r_dst_en;
    logic                      r_wrt;
    logic [CRF_ADDR_WIDTH-1:0] r_waddr;
    logic [CRF_DATA_WIDTH-1:0] r_wdata;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_abort;

    logic w_src_acc;
    logic w_dst_acc;
    logic w_src_last;
    logic w_dst_last;
    logic w_start;
    logic w_active;
    logic w_abort_go;
    logic w_frame_end;
    logic w_timeout;
    logic w_clr_cnt;
    logic w_unused;

    // Beats only count while the matching enable is up, so beats in IDLE/REPORT/DONE fall away here.
    assign w_src_acc   = src_beat & r_src_en;
    assign w_dst_acc   = dst_beat & r_dst_en;
    assign w_src_last  = w_src_acc & (r_src_col == SC_MAX) & (r_src_row == SR_MAX);
    assign w_dst_last  = w_dst_acc & (r_dst_col == DC_MAX) & (r_dst_row == DR_MAX);
    assign w_start     = crf_ac_UPSTR[0] & ~r_start_q;
    assign w_active    = (r_state == S_RUN) | (r_state == S_DRAIN);
    assign w_abort_go  = crf_ac_UPSTR[1] & (w_active | (r_state == S_REPORT));
    assign w_frame_end = ((r_state == S_RUN) & w_src_last & (w_dst_last | ~r_dst_en))
                       | ((r_state == S_DRAIN) & w_dst_last);
    assign w_clr_cnt   = w_abort_go | (r_state == S_DONE);

`ifdef FRAME_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_wdog;

    // r_wdog holds the number of consecutive beatless RUN/DRAIN cycles seen so far.
    assign w_timeout = w_active & ~(w_src_acc | w_dst_acc) & (r_wdog == TW'(TIMEOUT_CYCLES - 1));
    assign w_unused  = ^crf_ac_UPSTR[CRF_DATA_WIDTH-1:2];

    always_ff @(posedge clk) begin
        if (rst || !w_active || w_src_acc || w_dst_acc) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign w_unused  = ^{crf_ac_UPSTR[CRF_DATA_WIDTH-1:2], TIMEOUT_CYCLES[0]};
`endif

    always_ff @(posedge clk) begin
        if (rst || w_clr_cnt) begin
            r_src_col <= '0;
            r_src_row <= '0;
            r_dst_col <= '0;
            r_dst_row <= '0;
        end else begin
            if (w_src_acc) begin
                r_src_col <= (r_src_col == SC_MAX) ? '0 : r_src_col + 1'b1;
                if (r_src_col == SC_MAX) begin
                    r_src_row <= (r_src_row == SR_MAX) ? '0 : r_src_row + 1'b1;
                end
            end
            if (w_dst_acc) begin
                r_dst_col <= (r_dst_col == DC_MAX) ? '0 : r_dst_col + 1'b1;
                if (r_dst_col == DC_MAX) begin
                    r_dst_row <= (r_dst_row == DR_MAX) ? '0 : r_dst_row + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_start_q <= 1'b0;
            r_src_en  <= 1'b0;
            r_dst_en  <= 1'b0;
            r_wrt     <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_abort   <= 1'b0;
        end else begin
            r_start_q <= crf_ac_UPSTR[0];
            r_done    <= 1'b0;
            r_abort   <= 1'b0;
            if (w_abort_go) begin
                r_state  <= S_IDLE;
                r_src_en <= 1'b0;
                r_dst_en <= 1'b0;
                r_wrt    <= 1'b0;
                r_waddr  <= '0;
                r_wdata  <= '0;
                r_busy   <= 1'b0;
                r_abort  <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_start) begin
                            r_state  <= S_RUN;
                            r_src_en <= 1'b1;
                            r_dst_en <= 1'b1;
                            r_busy   <= 1'b1;
                        end
                    end
                    S_RUN, S_DRAIN: begin
                        if (w_frame_end || w_timeout) begin
                            r_state  <= S_REPORT;
                            r_src_en <= 1'b0;
                            r_dst_en <= 1'b0;
                            r_wrt    <= 1'b1;
                            r_waddr  <= UPENDR_ADDR;
                            r_wdata  <= w_timeout ? CODE_TO : CODE_OK;
                        end else if (r_state == S_RUN) begin
                            // A destination that finishes first stops taking beats while RUN waits for the source.
                            if (w_src_last) begin
                                r_state  <= S_DRAIN;
                                r_src_en <= 1'b0;
                            end else if (w_dst_last) begin
                                r_dst_en <= 1'b0;
                            end
                        end
                    end
                    S_REPORT: begin
                        if (!crf_ac_wbusy) begin
                            r_state <= S_DONE;
                            r_wrt   <= 1'b0;
                            r_waddr <= '0;
                            r_wdata <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign src_en       = r_src_en;
    assign dst_en       = r_dst_en;
    assign dst_eol      = r_dst_en & (r_dst_col == DC_MAX);
    assign dst_eof      = dst_eol & (r_dst_row == DR_MAX);
    assign ac_crf_wrt   = r_wrt;
    assign ac_crf_waddr = r_waddr;
    assign ac_crf_wdata = r_wdata;
    assign busy         = r_busy;
    assign done         = r_done;
    assign abort        = r_abort;
    assign dbg_state    = r_state;

endmodule
